eco32f_store_buffer: RTL and testbench
======================================

// Module: eco32f_store_buffer
// PURPOSE
//  Posted-write buffer between the data-side LSU Wishbone master and the system data bus.
//  Acks LSU stores after one cycle and drains them to the bus in order; loads/refills pass straight through.
//  A load is forwarded only once the buffer is empty, so a load never bypasses an older store.
// PARAMETERS
//  DEPTH_LOG2  2  log2 of entry count (default 4 entries of {adr[31:2],dat[31:0],sel[3:0]})
// PORTS
//  clk          in   1   clock; single clock domain
//  rst          in   1   synchronous active-high reset
//  lsu_adr_i    in   32  LSU address
//  lsu_dat_i    in   32  LSU write data
//  lsu_sel_i    in   4   byte selects
//  lsu_we_i     in   1   write enable
//  lsu_stb_i    in   1   strobe
//  lsu_cyc_i    in   1   cycle
//  lsu_cti_i    in   3   cycle type (010 incr burst, 111 end)
//  lsu_bte_i    in   2   burst type
//  lsu_dat_o    out  32  read data to LSU
//  lsu_ack_o    out  1   ack to LSU
//  lsu_err_o    out  1   read error to LSU
//  dwbm_adr_o   out  32  bus address
//  dwbm_dat_o   out  32  bus write data
//  dwbm_sel_o   out  4   bus byte selects
//  dwbm_we_o    out  1   bus write enable
//  dwbm_stb_o   out  1   bus strobe
//  dwbm_cyc_o   out  1   bus cycle
//  dwbm_cti_o   out  3   bus cycle type
//  dwbm_bte_o   out  2   bus burst type
//  dwbm_dat_i   in   32  bus read data
//  dwbm_ack_i   in   1   bus ack
//  dwbm_err_i   in   1   bus error
//  dwbm_rty_i   in   1   bus retry
//  sb_empty_o   out  1   buffer empty and no write on bus
//  sb_werr_o    out  1   1-cycle pulse: buffered write got dwbm_err_i (imprecise)
// BEHAVIOUR
//  Reset: FIFO count/pointers 0, state IDLE; lsu_ack_o, lsu_err_o, dwbm_cyc/stb/we_o, sb_werr_o = 0;
//   sb_empty_o = 1. Reset mid-transfer drops cyc/stb next cycle and discards queued stores.
//  Push: lsu_cyc&stb&we & !lsu_ack_o & count<DEPTH -> write entry, count+1, lsu_ack_o=1 next cycle
//   (one-cycle pulse). !lsu_ack_o gate prevents double capture while LSU drops stb.
//   Full: no ack; LSU holds stb until a slot frees.
//   Full test uses the current count; a same-cycle pop does not admit a push.
//  States: IDLE, WRITE, RETRY, READ.
//  IDLE:
//   - count!=0 -> WRITE: drive head entry registered, cyc=stb=we=1, cti=111, bte=00.
//   - else lsu_cyc&stb&!we -> READ.
//   - Writes take priority over a waiting read.
//  WRITE:
//   - dwbm_ack_i: pop, drop cyc/stb/we, ->IDLE. No back-to-back cycles; one idle cycle between entries.
//   - dwbm_err_i: pop, sb_werr_o=1 for one cycle, ->IDLE.
//   - dwbm_rty_i: keep entry, drop stb/cyc, ->RETRY; RETRY reissues same entry next cycle (->WRITE).
//   - ack/err/rty together: err > ack > rty.
//  READ: combinational pass-through.
//   - dwbm_{adr,sel,cti,bte,cyc,stb} = lsu_*; we=0.
//   - lsu_dat_o=dwbm_dat_i; lsu_ack_o=dwbm_ack_i; lsu_err_o=dwbm_err_i.
//   - Exit to IDLE when lsu_cyc_i=0. Pushes are blocked in READ. Bursts (8-beat refill, cti 010) pass unchanged.
//  Outside READ: lsu_dat_o=0, lsu_err_o=0.
//  sb_empty_o = (count==0) & state!=WRITE & state!=RETRY.
//   LSU/exception logic waits on it before a non-cached access needing ordering.
//  Pointers wrap modulo 2**DEPTH_LOG2; count is DEPTH_LOG2+1 bits.
// TESTING
//  - Single store adr=0x0000_1004 dat=0xA5A5_0000 sel=1100 -> lsu_ack 1 cycle later;
//    bus write same adr/dat/sel, cti=111; sb_empty_o returns 1 after ack.
//  - 5 back-to-back stores, bus ack stalled -> 4 acked; 5th acked only after first bus ack;
//    bus order = issue order.
//  - Store to 0x100 then load 0x100 -> read cyc not asserted until write acked;
//    load returns bus data 0x1234_5678.
//  - 8-beat refill at 0x0000_2000 with stores queued -> stores drain first;
//    8 acks forwarded 1:1, cti 010...111.
//  - Buffered write gets dwbm_rty_i once then ack -> same entry reissued, one pop, no sb_werr_o.
//    With dwbm_err_i instead -> sb_werr_o pulses 1 cycle, entry dropped.
//  - rst asserted during WRITE with 3 queued -> cyc/stb=0 next cycle, sb_empty_o=1, no further bus writes.

Source files
------------

// File: rtl/eco32f_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : eco32f_store_buffer
//  Purpose  : Posted-write buffer between the data-side LSU Wishbone master
//             and the system data bus. LSU stores are acked one cycle after
//             capture and drained to the bus in issue order. Loads and
//             refills pass straight through, but only once the buffer is
//             empty, so a load can never overtake an older store.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             lsu_*_i / lsu_*_o    - Wishbone slave side facing the LSU
//             dwbm_*_o / dwbm_*_i  - Wishbone master side facing the bus
//             sb_empty_o           - no queued store and no write in flight
//             sb_werr_o            - one-cycle pulse, buffered write errored
//  Revision : 1.0 - initial release
// ============================================================================
module eco32f_store_buffer #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lsu_adr_i,
  input  logic [31:0] lsu_dat_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic        lsu_we_i,
  input  logic        lsu_stb_i,
  input  logic        lsu_cyc_i,
  input  logic [2:0]  lsu_cti_i,
  input  logic [1:0]  lsu_bte_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  output logic [31:0] dwbm_adr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_cyc_o,
  output logic [2:0]  dwbm_cti_o,
  output logic [1:0]  dwbm_bte_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i,
  input  logic        dwbm_rty_i,
  output logic        sb_empty_o,
  output logic        sb_werr_o
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_DEPTH    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] c_CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_RETRY = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  // Entry storage: word address, data, byte selects
  logic [29:0] r_fifo_adr [DEPTH];
  logic [31:0] r_fifo_dat [DEPTH];
  logic [3:0]  r_fifo_sel [DEPTH];

  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count, w_count_nxt;

  // Head entry held stable for the whole write (including retries)
  logic [29:0] r_wadr;
  logic [31:0] r_wdat;
  logic [3:0]  r_wsel;

  logic r_ack;
  logic r_werr;

  logic w_push, w_pop, w_load_head;

  // r_ack gate stops the same store being captured twice while the LSU
  // is still holding stb in the cycle it sees the ack.
  assign w_push = lsu_cyc_i & lsu_stb_i & lsu_we_i & ~r_ack
                & (r_count < c_DEPTH) & (r_state != S_READ);
  assign w_pop  = (r_state == S_WRITE) & (dwbm_err_i | dwbm_ack_i);
  assign w_load_head = (r_state == S_IDLE) & (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_ONE;
      2'b01:   w_count_nxt = r_count - c_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // Queued writes win over a waiting read to keep ordering
        if (r_count != '0)
          w_state_nxt = S_WRITE;
        else if (lsu_cyc_i && lsu_stb_i && !lsu_we_i)
          w_state_nxt = S_READ;
      end
      S_WRITE: begin
        if (dwbm_err_i || dwbm_ack_i)
          w_state_nxt = S_IDLE;
        else if (dwbm_rty_i)
          w_state_nxt = S_RETRY;
      end
      S_RETRY: w_state_nxt = S_WRITE;
      S_READ: begin
        if (!lsu_cyc_i)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_werr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ack   <= w_push;
      r_werr  <= (r_state == S_WRITE) & dwbm_err_i;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_adr[r_wr_ptr] <= lsu_adr_i[31:2];
      r_fifo_dat[r_wr_ptr] <= lsu_dat_i;
      r_fifo_sel[r_wr_ptr] <= lsu_sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wadr <= '0;
      r_wdat <= '0;
      r_wsel <= '0;
    end else if (w_load_head) begin
      r_wadr <= r_fifo_adr[r_rd_ptr];
      r_wdat <= r_fifo_dat[r_rd_ptr];
      r_wsel <= r_fifo_sel[r_rd_ptr];
    end
  end

  // Bus/LSU output muxing: READ is a combinational pass-through,
  // everything else presents the registered head entry.
  always_comb begin
    dwbm_adr_o = {r_wadr, 2'b00};
    dwbm_dat_o = r_wdat;
    dwbm_sel_o = r_wsel;
    dwbm_we_o  = (r_state == S_WRITE);
    dwbm_stb_o = (r_state == S_WRITE);
    dwbm_cyc_o = (r_state == S_WRITE);
    dwbm_cti_o = 3'b111;
    dwbm_bte_o = 2'b00;
    lsu_dat_o  = '0;
    lsu_ack_o  = r_ack;
    lsu_err_o  = 1'b0;
    if (r_state == S_READ) begin
      dwbm_adr_o = lsu_adr_i;
      dwbm_sel_o = lsu_sel_i;
      dwbm_we_o  = 1'b0;
      dwbm_stb_o = lsu_stb_i;
      dwbm_cyc_o = lsu_cyc_i;
      dwbm_cti_o = lsu_cti_i;
      dwbm_bte_o = lsu_bte_i;
      lsu_dat_o  = dwbm_dat_i;
      lsu_ack_o  = dwbm_ack_i;
      lsu_err_o  = dwbm_err_i;
    end
  end

  assign sb_empty_o = (r_count == '0) & (r_state != S_WRITE) & (r_state != S_RETRY);
  assign sb_werr_o  = r_werr;

endmodule
`default_nettype wire

// File: tb/tb_eco32f_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eco32f_store_buffer
//  Purpose  : Directed self-checking bench for eco32f_store_buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eco32f_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lsu_adr_i, lsu_dat_i;
  logic [3:0]  lsu_sel_i;
  logic        lsu_we_i, lsu_stb_i, lsu_cyc_i;
  logic [2:0]  lsu_cti_i;
  logic [1:0]  lsu_bte_i;
  logic [31:0] lsu_dat_o;
  logic        lsu_ack_o, lsu_err_o;
  logic [31:0] dwbm_adr_o, dwbm_dat_o;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_we_o, dwbm_stb_o, dwbm_cyc_o;
  logic [2:0]  dwbm_cti_o;
  logic [1:0]  dwbm_bte_o;
  logic [31:0] dwbm_dat_i;
  logic        dwbm_ack_i, dwbm_err_i, dwbm_rty_i;
  logic        sb_empty_o, sb_werr_o;

  int n_tests = 0;
  int n_fail  = 0;
  int werr_cnt = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic        lack;
    logic [31:0] ldat;
    logic        lerr;
  } obs_t;

  eco32f_store_buffer #(.DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .lsu_adr_i(lsu_adr_i), .lsu_dat_i(lsu_dat_i), .lsu_sel_i(lsu_sel_i),
    .lsu_we_i(lsu_we_i), .lsu_stb_i(lsu_stb_i), .lsu_cyc_i(lsu_cyc_i),
    .lsu_cti_i(lsu_cti_i), .lsu_bte_i(lsu_bte_i),
    .lsu_dat_o(lsu_dat_o), .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o),
    .dwbm_adr_o(dwbm_adr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
    .dwbm_we_o(dwbm_we_o), .dwbm_stb_o(dwbm_stb_o), .dwbm_cyc_o(dwbm_cyc_o),
    .dwbm_cti_o(dwbm_cti_o), .dwbm_bte_o(dwbm_bte_o),
    .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i),
    .dwbm_rty_i(dwbm_rty_i),
    .sb_empty_o(sb_empty_o), .sb_werr_o(sb_werr_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sb_werr_o === 1'b1) werr_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic lsu_idle();
    lsu_cyc_i = 0; lsu_stb_i = 0; lsu_we_i = 0;
    lsu_adr_i = '0; lsu_dat_i = '0; lsu_sel_i = '0;
    lsu_cti_i = 3'b111; lsu_bte_i = 2'b00;
  endtask

  task automatic lsu_store(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output bit acked);
    @(posedge clk); #1;
    lsu_cyc_i = 1; lsu_stb_i = 1; lsu_we_i = 1;
    lsu_adr_i = adr; lsu_dat_i = dat; lsu_sel_i = sel; lsu_cti_i = 3'b111;
    acked = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lsu_ack_o === 1'b1) begin acked = 1; break; end
    end
    // hold stb through the edge where the LSU samples ack
    @(posedge clk); #1;
    lsu_idle();
  endtask

  // Wait for a bus cycle, answer it for one clock, record what was seen.
  task automatic bus_respond(input bit a, input bit e, input bit r,
                             input logic [31:0] rdat,
                             output bit ok, output obs_t o);
    ok = 0;
    o = '{default: '0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dwbm_cyc_o === 1'b1 && dwbm_stb_o === 1'b1) begin
        o.adr = dwbm_adr_o; o.dat = dwbm_dat_o; o.sel = dwbm_sel_o;
        o.we = dwbm_we_o; o.cti = dwbm_cti_o;
        dwbm_ack_i = a; dwbm_err_i = e; dwbm_rty_i = r; dwbm_dat_i = rdat;
        #1;
        o.lack = lsu_ack_o; o.ldat = lsu_dat_o; o.lerr = lsu_err_o;
        @(posedge clk); #1;
        dwbm_ack_i = 0; dwbm_err_i = 0; dwbm_rty_i = 0; dwbm_dat_i = '0;
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; lsu_idle();
    dwbm_ack_i = 0; dwbm_err_i = 0; dwbm_rty_i = 0; dwbm_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({lsu_ack_o, lsu_err_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, sb_werr_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000",
               {lsu_ack_o, lsu_err_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, sb_werr_o});
    end
    n_tests++;
    if (sb_empty_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_empty: got %b required 1", sb_empty_o);
    end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_single_store();
    bit ok; obs_t o; int cyc_seen;
    @(posedge clk); #1;
    lsu_cyc_i = 1; lsu_stb_i = 1; lsu_we_i = 1;
    lsu_adr_i = 32'h0000_1004; lsu_dat_i = 32'hA5A5_0000; lsu_sel_i = 4'b1100;
    @(negedge clk);
    n_tests++;
    if (lsu_ack_o !== 1'b0) begin n_fail++; $display("FAIL single_ack_early: got %b required 0", lsu_ack_o); end
    @(negedge clk);
    n_tests++;
    if (lsu_ack_o !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b required 1", lsu_ack_o); end
    n_tests++;
    if (sb_empty_o !== 1'b0) begin n_fail++; $display("FAIL single_not_empty: got %b required 0", sb_empty_o); end
    @(posedge clk); #1;
    lsu_idle();
    @(negedge clk);
    n_tests++;
    if (lsu_ack_o !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b required 0", lsu_ack_o); end
    bus_respond(1, 0, 0, '0, ok, o);
    n_tests++;
    if (!ok || o.adr !== 32'h0000_1004 || o.dat !== 32'hA5A5_0000 || o.sel !== 4'b1100 ||
        o.we !== 1'b1 || o.cti !== 3'b111) begin
      n_fail++;
      $display("FAIL single_bus_write: ok=%0d adr=%h dat=%h sel=%b we=%b cti=%b required adr=00001004 dat=a5a50000 sel=1100 we=1 cti=111",
               ok, o.adr, o.dat, o.sel, o.we, o.cti);
    end
    @(negedge clk);
    n_tests++;
    if (sb_empty_o !== 1'b1) begin n_fail++; $display("FAIL single_empty_after: got %b required 1", sb_empty_o); end
    cyc_seen = 0;
    repeat (4) begin @(negedge clk); if (dwbm_cyc_o === 1'b1) cyc_seen++; end
    n_tests++;
    if (cyc_seen != 0) begin n_fail++; $display("FAIL single_no_dup: got %0d extra bus cycles required 0", cyc_seen); end
  endtask

  task automatic test_back_to_back();
    bit ok, acked; obs_t o; int nack; int early;
    logic [31:0] adrs [5];
    logic [31:0] dats [5];
    for (int i = 0; i < 5; i++) begin
      adrs[i] = 32'h0000_0200 + 32'(i * 4);
      dats[i] = 32'h5000_0000 + 32'(i);
    end
    nack = 0;
    for (int i = 0; i < 4; i++) begin
      lsu_store(adrs[i], dats[i], 4'hF, acked);
      if (acked) nack++;
    end
    n_tests++;
    if (nack != 4) begin n_fail++; $display("FAIL b2b_four_acked: got %0d required 4", nack); end
    @(posedge clk); #1;
    lsu_cyc_i = 1; lsu_stb_i = 1; lsu_we_i = 1;
    lsu_adr_i = adrs[4]; lsu_dat_i = dats[4]; lsu_sel_i = 4'hF;
    early = 0;
    repeat (6) begin @(negedge clk); if (lsu_ack_o === 1'b1) early++; end
    n_tests++;
    if (early != 0) begin n_fail++; $display("FAIL b2b_full_no_ack: got %0d acks required 0", early); end
    bus_respond(1, 0, 0, '0, ok, o);
    n_tests++;
    if (!ok || o.adr !== adrs[0] || o.dat !== dats[0]) begin
      n_fail++; $display("FAIL b2b_order0: ok=%0d adr=%h dat=%h required %h %h", ok, o.adr, o.dat, adrs[0], dats[0]);
    end
    acked = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lsu_ack_o === 1'b1) begin acked = 1; break; end
    end
    n_tests++;
    if (!acked) begin n_fail++; $display("FAIL b2b_fifth_ack: got 0 required 1"); end
    @(posedge clk); #1;
    lsu_idle();
    for (int i = 1; i < 5; i++) begin
      bus_respond(1, 0, 0, '0, ok, o);
      n_tests++;
      if (!ok || o.adr !== adrs[i] || o.dat !== dats[i] || o.we !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_order%0d: ok=%0d adr=%h dat=%h we=%b required %h %h 1", i, ok, o.adr, o.dat, o.we, adrs[i], dats[i]);
      end
    end
  endtask

  task automatic test_load_after_store();
    bit ok, acked; obs_t o;
    lsu_store(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, acked);
    lsu_cyc_i = 1; lsu_stb_i = 1; lsu_we_i = 0;
    lsu_adr_i = 32'h0000_0100; lsu_sel_i = 4'hF; lsu_cti_i = 3'b111;
    bus_respond(1, 0, 0, '0, ok, o);
    n_tests++;
    if (!acked || !ok || o.we !== 1'b1 || o.adr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL load_write_first: acked=%0d ok=%0d we=%b adr=%h required 1 1 1 00000100", acked, ok, o.we, o.adr);
    end
    bus_respond(1, 0, 0, 32'h1234_5678, ok, o);
    n_tests++;
    if (!ok || o.we !== 1'b0 || o.adr !== 32'h0000_0100 || o.lack !== 1'b1 ||
        o.ldat !== 32'h1234_5678 || o.lerr !== 1'b0) begin
      n_fail++;
      $display("FAIL load_data: ok=%0d we=%b adr=%h lack=%b ldat=%h lerr=%b required 1 0 00000100 1 12345678 0",
               ok, o.we, o.adr, o.lack, o.ldat, o.lerr);
    end
    lsu_idle();
    @(negedge clk);
    n_tests++;
    if (lsu_dat_o !== 32'h0 || lsu_ack_o !== 1'b0 || dwbm_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL load_exit: dat=%h ack=%b cyc=%b required 00000000 0 0", lsu_dat_o, lsu_ack_o, dwbm_cyc_o);
    end
  endtask

  task automatic test_refill();
    bit ok, a0, a1; obs_t o; logic [2:0] exp_cti;
    lsu_store(32'h0000_0300, 32'h0300_0300, 4'hF, a0);
    lsu_store(32'h0000_0304, 32'h0304_0304, 4'hF, a1);
    lsu_cyc_i = 1; lsu_stb_i = 1; lsu_we_i = 0; lsu_sel_i = 4'hF;
    lsu_adr_i = 32'h0000_2000; lsu_cti_i = 3'b010; lsu_bte_i = 2'b00;
    bus_respond(1, 0, 0, '0, ok, o);
    n_tests++;
    if (!a0 || !ok || o.we !== 1'b1 || o.adr !== 32'h0000_0300) begin
      n_fail++; $display("FAIL refill_drain0: ok=%0d we=%b adr=%h required 1 1 00000300", ok, o.we, o.adr);
    end
    bus_respond(1, 0, 0, '0, ok, o);
    n_tests++;
    if (!a1 || !ok || o.we !== 1'b1 || o.adr !== 32'h0000_0304) begin
      n_fail++; $display("FAIL refill_drain1: ok=%0d we=%b adr=%h required 1 1 00000304", ok, o.we, o.adr);
    end
    for (int i = 0; i < 8; i++) begin
      exp_cti = (i == 7) ? 3'b111 : 3'b010;
      bus_respond(1, 0, 0, 32'hC000_0000 + 32'(i), ok, o);
      n_tests++;
      if (!ok || o.we !== 1'b0 || o.adr !== 32'h0000_2000 + 32'(i * 4) || o.cti !== exp_cti ||
          o.lack !== 1'b1 || o.ldat !== 32'hC000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL refill_beat%0d: ok=%0d we=%b adr=%h cti=%b lack=%b ldat=%h required we=0 adr=%h cti=%b lack=1 ldat=%h",
                 i, ok, o.we, o.adr, o.cti, o.lack, o.ldat, 32'h0000_2000 + 32'(i * 4), exp_cti, 32'hC000_0000 + 32'(i));
      end
      lsu_adr_i = 32'h0000_2000 + 32'((i + 1) * 4);
      lsu_cti_i = (i == 6) ? 3'b111 : 3'b010;
    end
    lsu_idle();
    @(negedge clk);
  endtask

  task automatic test_retry_err();
    bit ok, acked; obs_t o1, o2; int w0, cyc_seen;
    w0 = werr_cnt;
    lsu_store(32'h0000_0400, 32'h1111_2222, 4'b0011, acked);
    bus_respond(0, 0, 1, '0, ok, o1);
    @(negedge clk);
    n_tests++;
    if (dwbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL retry_drop_cyc: got %b required 0", dwbm_cyc_o); end
    bus_respond(1, 0, 0, '0, ok, o2);
    n_tests++;
    if (!acked || !ok || o1.adr !== 32'h0000_0400 || o2.adr !== 32'h0000_0400 ||
        o2.dat !== 32'h1111_2222 || o2.sel !== 4'b0011) begin
      n_fail++; $display("FAIL retry_reissue: ok=%0d adr1=%h adr2=%h dat=%h sel=%b required 00000400 00000400 11112222 0011",
                         ok, o1.adr, o2.adr, o2.dat, o2.sel);
    end
    cyc_seen = 0;
    repeat (3) begin @(negedge clk); if (dwbm_cyc_o === 1'b1) cyc_seen++; end
    n_tests++;
    if (cyc_seen != 0 || sb_empty_o !== 1'b1 || werr_cnt != w0) begin
      n_fail++; $display("FAIL retry_single_pop: extra_cyc=%0d empty=%b werr=%0d required 0 1 0", cyc_seen, sb_empty_o, werr_cnt - w0);
    end
    // err, ack and rty together: err must win
    w0 = werr_cnt;
    lsu_store(32'h0000_0500, 32'h3333_4444, 4'hF, acked);
    bus_respond(1, 1, 1, '0, ok, o1);
    n_tests++;
    if (!acked || !ok || o1.adr !== 32'h0000_0500 || o1.lerr !== 1'b0) begin
      n_fail++; $display("FAIL err_bus_write: ok=%0d adr=%h lerr=%b required 1 00000500 0", ok, o1.adr, o1.lerr);
    end
    cyc_seen = 0;
    repeat (4) begin @(negedge clk); if (dwbm_cyc_o === 1'b1) cyc_seen++; end
    n_tests++;
    if (werr_cnt - w0 != 1) begin n_fail++; $display("FAIL err_werr_pulse: got %0d cycles required 1", werr_cnt - w0); end
    n_tests++;
    if (cyc_seen != 0 || sb_empty_o !== 1'b1) begin
      n_fail++; $display("FAIL err_dropped: extra_cyc=%0d empty=%b required 0 1", cyc_seen, sb_empty_o);
    end
  endtask

  task automatic test_reset_midwrite();
    bit a; int nack, cyc_seen;
    nack = 0;
    for (int i = 0; i < 3; i++) begin
      lsu_store(32'h0000_0600 + 32'(i * 4), 32'h7700_0000 + 32'(i), 4'hF, a);
      if (a) nack++;
    end
    @(negedge clk);
    n_tests++;
    if (nack != 3 || dwbm_cyc_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_setup: acks=%0d cyc=%b required 3 1", nack, dwbm_cyc_o);
    end
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1;
    n_tests++;
    if (dwbm_cyc_o !== 1'b0 || dwbm_stb_o !== 1'b0 || sb_empty_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_drop: cyc=%b stb=%b empty=%b required 0 0 1", dwbm_cyc_o, dwbm_stb_o, sb_empty_o);
    end
    rst = 0;
    cyc_seen = 0;
    repeat (10) begin @(negedge clk); if (dwbm_cyc_o === 1'b1) cyc_seen++; end
    n_tests++;
    if (cyc_seen != 0 || sb_empty_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_discard: bus_cycles=%0d empty=%b required 0 1", cyc_seen, sb_empty_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_back_to_back();
    test_load_after_store();
    test_refill();
    test_retry_err();
    test_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
